// File: rtl/pe_conv_ctrl.sv
// Convolution sequencer: feeds one 10x10 image of 2-bit pixels through an external 3-tap PE, one filter row at a time.
// Optional macro PE_CONV_CTRL_ROWBUF_EN adds a 3-row image buffer so that each later output row needs only one fetch.
module pe_conv_ctrl #(
   parameter int unsigned ACC_W = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [17:0]          filt,
   output logic                 busy,
   output logic                 row_req,
   output logic [3:0]           row_addr,
   input  logic [19:0]          row_data,
   input  logic                 row_valid,
   output logic [19:0]          pe_in,
   output logic [5:0]           pe_filter,
   input  logic [15:0]          pe_out,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [8*ACC_W-1:0]   out_data,
   output logic [2:0]           out_row,
   output logic                 done
);

   localparam int unsigned LANES  = 8;
   localparam int unsigned ROW_W  = 20;
   localparam int unsigned FROW_W = 6;
   localparam int unsigned FILT_W = 18;

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_ACC,
      S_EMIT,
      S_DONE
   } state_e;

   state_e                          state_q, state_d;
   logic [2:0]                      r_q, r_d;
   logic [1:0]                      k_q, k_d;
   logic [FILT_W-1:0]               filt_q, filt_d;
   logic [ROW_W-1:0]                pe_in_q, pe_in_d;
   logic [FROW_W-1:0]               pe_filter_q, pe_filter_d;
   logic [LANES-1:0][ACC_W-1:0]     acc_q, acc_d;
   logic                            busy_q, busy_d;
   logic                            row_req_q, row_req_d;
   logic [3:0]                      row_addr_q, row_addr_d;
   logic                            out_valid_q, out_valid_d;
   logic [2:0]                      out_row_q, out_row_d;
   logic                            done_q, done_d;
`ifdef PE_CONV_CTRL_ROWBUF_EN
   logic [2:0][ROW_W-1:0]           rbuf_q, rbuf_d;
`endif

   function automatic logic [FROW_W-1:0] filt_row(input logic [FILT_W-1:0] f, input logic [1:0] k);
      case (k)
         2'd0:    return f[5:0];
         2'd1:    return f[11:6];
         default: return f[17:12];
      endcase
   endfunction

   // Next-state, datapath and registered-output computation
   always_comb begin
      state_d     = state_q;
      r_d         = r_q;
      k_d         = k_q;
      filt_d      = filt_q;
      pe_in_d     = pe_in_q;
      pe_filter_d = pe_filter_q;
      acc_d       = acc_q;
`ifdef PE_CONV_CTRL_ROWBUF_EN
      rbuf_d      = rbuf_q;
`endif

      case (state_q)
         S_IDLE: begin
            if (start) begin
               filt_d  = filt;
               r_d     = 3'd0;
               k_d     = 2'd0;
               acc_d   = '0;
               state_d = S_FETCH;
            end
         end
         S_FETCH: begin
            if (row_valid) begin
`ifdef PE_CONV_CTRL_ROWBUF_EN
               // Row 0 fills the buffer in place; later rows shift in a single new image row
               if (r_q == 3'd0) begin
                  rbuf_d[k_q] = row_data;
               end else begin
                  rbuf_d = {row_data, rbuf_q[2], rbuf_q[1]};
               end
               if (k_q == 2'd2) begin
                  pe_in_d     = (r_q == 3'd0) ? rbuf_q[0] : rbuf_q[1];
                  pe_filter_d = filt_row(filt_q, 2'd0);
                  k_d         = 2'd0;
                  state_d     = S_ACC;
               end else begin
                  k_d = k_q + 2'd1;
               end
`else
               pe_in_d     = row_data;
               pe_filter_d = filt_row(filt_q, k_q);
               state_d     = S_ACC;
`endif
            end
         end
         S_ACC: begin
            for (int j = 0; j < int'(LANES); j++) begin
               acc_d[j] = acc_q[j] + ACC_W'(pe_out[2*j +: 2]);
            end
            if (k_q == 2'd2) begin
               state_d = S_EMIT;
            end else begin
               k_d = k_q + 2'd1;
`ifdef PE_CONV_CTRL_ROWBUF_EN
               pe_in_d     = rbuf_q[k_d];
               pe_filter_d = filt_row(filt_q, k_d);
`else
               state_d = S_FETCH;
`endif
            end
         end
         S_EMIT: begin
            if (out_ready) begin
               if (r_q == 3'd7) begin
                  state_d = S_DONE;
               end else begin
                  r_d     = r_q + 3'd1;
`ifdef PE_CONV_CTRL_ROWBUF_EN
                  k_d     = 2'd2;
`else
                  k_d     = 2'd0;
`endif
                  acc_d   = '0;
                  state_d = S_FETCH;
               end
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // Status outputs are decoded from the next state so they register alongside it
      busy_d      = (state_d != S_IDLE);
      row_req_d   = (state_d == S_FETCH);
      row_addr_d  = (state_d == S_FETCH) ? (4'(r_d) + 4'(k_d)) : 4'd0;
      out_valid_d = (state_d == S_EMIT);
      out_row_d   = (state_d == S_EMIT) ? r_d : 3'd0;
      done_d      = (state_d == S_DONE);
   end

   // State and datapath registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         r_q         <= '0;
         k_q         <= '0;
         filt_q      <= '0;
         pe_in_q     <= '0;
         pe_filter_q <= '0;
         acc_q       <= '0;
         busy_q      <= 1'b0;
         row_req_q   <= 1'b0;
         row_addr_q  <= '0;
         out_valid_q <= 1'b0;
         out_row_q   <= '0;
         done_q      <= 1'b0;
`ifdef PE_CONV_CTRL_ROWBUF_EN
         rbuf_q      <= '0;
`endif
      end else begin
         state_q     <= state_d;
         r_q         <= r_d;
         k_q         <= k_d;
         filt_q      <= filt_d;
         pe_in_q     <= pe_in_d;
         pe_filter_q <= pe_filter_d;
         acc_q       <= acc_d;
         busy_q      <= busy_d;
         row_req_q   <= row_req_d;
         row_addr_q  <= row_addr_d;
         out_valid_q <= out_valid_d;
         out_row_q   <= out_row_d;
         done_q      <= done_d;
`ifdef PE_CONV_CTRL_ROWBUF_EN
         rbuf_q      <= rbuf_d;
`endif
      end
   end

   assign busy      = busy_q;
   assign row_req   = row_req_q;
   assign row_addr  = row_addr_q;
   assign pe_in     = pe_in_q;
   assign pe_filter = pe_filter_q;
   assign out_valid = out_valid_q;
   assign out_data  = acc_q;
   assign out_row   = out_row_q;
   assign done      = done_q;

endmodule

// File: tb/tb_pe_conv_ctrl.sv
// Bench for pe_conv_ctrl: image memory, 3-tap PE model and a per-row convolution reference built from the filter/image arrays.
module tb_pe_conv_ctrl;

   localparam int unsigned ACC_W = 4;
   localparam int unsigned OUT_W = 8 * ACC_W;

   logic             clk;
   logic             rst;
   logic             start;
   logic [17:0]      filt;
   logic             busy;
   logic             row_req;
   logic [3:0]       row_addr;
   logic [19:0]      row_data;
   logic             row_valid;
   logic [19:0]      pe_in;
   logic [5:0]       pe_filter;
   logic [15:0]      pe_out;
   logic             out_valid;
   logic             out_ready;
   logic [OUT_W-1:0] out_data;
   logic [2:0]       out_row;
   logic             done;

   int total = 0;
   int bad   = 0;

   logic [1:0] img [10][10];

   pe_conv_ctrl #(.ACC_W(ACC_W)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .filt      (filt),
      .busy      (busy),
      .row_req   (row_req),
      .row_addr  (row_addr),
      .row_data  (row_data),
      .row_valid (row_valid),
      .pe_in     (pe_in),
      .pe_filter (pe_filter),
      .pe_out    (pe_out),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_row   (out_row),
      .done      (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // External PE: lane j = dot(pixels j..j+2, taps 0..2) mod 4
   function automatic logic [15:0] pe_model(input logic [19:0] px, input logic [5:0] tp);
      logic [15:0] res;
      int s;
      res = '0;
      for (int j = 0; j < 8; j++) begin
         s = 0;
         for (int t = 0; t < 3; t++) s += int'(px[2*(j+t) +: 2]) * int'(tp[2*t +: 2]);
         res[2*j +: 2] = 2'(s % 4);
      end
      return res;
   endfunction

   assign pe_out = pe_model(pe_in, pe_filter);

   function automatic logic [19:0] row_word(input logic [3:0] a);
      logic [19:0] w;
      w = '0;
      if (a < 4'd10) for (int c = 0; c < 10; c++) w[2*c +: 2] = img[a][c];
      return w;
   endfunction

   // Output row r: sum over filter rows k of the PE result (mod 4) for image row r+k
   function automatic logic [OUT_W-1:0] exp_row(input int r, input logic [17:0] f);
      logic [OUT_W-1:0] v;
      int acc;
      int s;
      v = '0;
      for (int j = 0; j < 8; j++) begin
         acc = 0;
         for (int k = 0; k < 3; k++) begin
            s = 0;
            for (int t = 0; t < 3; t++) s += int'(img[r+k][j+t]) * int'(f[6*k + 2*t +: 2]);
            acc += s % 4;
         end
         v[ACC_W*j +: ACC_W] = ACC_W'(acc);
      end
      return v;
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic fill_random();
      for (int r = 0; r < 10; r++) for (int c = 0; c < 10; c++) img[r][c] = 2'($urandom);
   endtask

   // One full image: vmode 1 = row_valid always, rmode 1 = always ready, 2 = stall row 3 for 10 cycles
   task automatic run_image(input logic [17:0] f, input int vmode, input int rmode, input bit extra_start);
      logic [OUT_W-1:0] exp_q [8];
      int addr_q [$];
      int rows_done, fetch_cnt, stall, exp_fetch, period;
      int first_emit [8];
      bit seen_row [8];
      bit seen_done;
      for (int r = 0; r < 8; r++) begin
         exp_q[r] = exp_row(r, f);
         seen_row[r] = 1'b0;
         first_emit[r] = 0;
      end
`ifdef PE_CONV_CTRL_ROWBUF_EN
      for (int a = 0; a < 10; a++) addr_q.push_back(a);
      exp_fetch = 10;
      period = 5;
`else
      for (int r = 0; r < 8; r++) for (int k = 0; k < 3; k++) addr_q.push_back(r + k);
      exp_fetch = 24;
      period = 7;
`endif
      rows_done = 0;
      fetch_cnt = 0;
      stall = 0;
      seen_done = 1'b0;
      @(negedge clk);
      start = 1'b1;
      filt = f;
      @(negedge clk);
      start = 1'b0;
      filt = 18'($urandom);
      check("busy_after_start", busy, 1);
      for (int cyc = 0; cyc < 3000 && !seen_done; cyc++) begin
         if (extra_start) begin
            start = (cyc == 15);
            filt = 18'($urandom);
         end
         out_ready = 1'($urandom);
         if (out_valid && rows_done < 8) begin
            if (!seen_row[rows_done]) begin
               seen_row[rows_done] = 1'b1;
               first_emit[rows_done] = cyc;
            end
            check("emit_row_req", row_req, 0);
            check("out_row", out_row, 64'(rows_done));
            check("out_data", out_data, exp_q[rows_done]);
            if (rmode == 1) out_ready = 1'b1;
            else if (rmode == 2) begin
               if (rows_done == 3 && stall < 10) begin
                  out_ready = 1'b0;
                  stall++;
               end else out_ready = 1'b1;
            end
            if (out_ready) rows_done++;
         end
         if (row_req) begin
            row_valid = (vmode == 1) ? 1'b1 : 1'($urandom);
            row_data = row_word(row_addr);
            if (row_valid) begin
               fetch_cnt++;
               if (addr_q.size() == 0) check("fetch_overflow", 64'(fetch_cnt), 64'(exp_fetch));
               else check("row_addr", row_addr, 64'(addr_q.pop_front()));
            end
         end else begin
            row_valid = 1'($urandom);
            row_data = 20'($urandom);
         end
         if (done) begin
            check("rows_at_done", 64'(rows_done), 8);
            seen_done = 1'b1;
         end
         @(negedge clk);
      end
      check("done_seen", seen_done, 1);
      check("done_one_cycle", done, 0);
      check("busy_after_done", busy, 0);
      check("valid_after_done", out_valid, 0);
      check("fetch_count", 64'(fetch_cnt), 64'(exp_fetch));
      if (rmode == 2) check("stall_cycles", 64'(stall), 10);
      if (vmode == 1 && rmode == 1) begin
         for (int r = 1; r < 8; r++)
            check("row_period", 64'(first_emit[r] - first_emit[r-1]), 64'(period));
      end
      start = 1'b0;
      row_valid = 1'b0;
      out_ready = 1'b0;
   endtask

   initial begin
      bit hit;
      rst = 1'b1;
      start = 1'b0;
      filt = '0;
      row_valid = 1'b0;
      row_data = '0;
      out_ready = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      check("rst_busy", busy, 0);
      check("rst_row_req", row_req, 0);
      check("rst_row_addr", row_addr, 0);
      check("rst_out_valid", out_valid, 0);
      check("rst_out_data", out_data, 0);
      check("rst_out_row", out_row, 0);
      check("rst_done", done, 0);
      check("rst_pe_in", pe_in, 0);
      check("rst_pe_filter", pe_filter, 0);

      // All-ones image and taps: every lane sums to 9
      for (int r = 0; r < 10; r++) for (int c = 0; c < 10; c++) img[r][c] = 2'd1;
      run_image(18'h15555, 1, 1, 1'b0);

      // Centre tap only over a diagonal-ramp image
      for (int r = 0; r < 10; r++) for (int c = 0; c < 10; c++) img[r][c] = 2'((r + c) % 4);
      run_image(18'h00100, 0, 0, 1'b0);

      // Zero filter over random pixels
      fill_random();
      run_image(18'h00000, 0, 0, 1'b0);

      // Consumer stall at row 3
      fill_random();
      run_image(18'($urandom), 0, 2, 1'b0);

      // Random images with a stray start while busy
      fill_random();
      run_image(18'($urandom), 0, 0, 1'b1);
      fill_random();
      run_image(18'($urandom), 1, 1, 1'b1);

      // Reset while the third fetch (row 2) is outstanding
      fill_random();
      @(negedge clk);
      start = 1'b1;
      filt = 18'($urandom);
      @(negedge clk);
      start = 1'b0;
      hit = 1'b0;
      for (int i = 0; i < 100 && !hit; i++) begin
         if (row_req && row_addr == 4'd2) hit = 1'b1;
         else begin
            row_valid = row_req;
            row_data = row_word(row_addr);
            @(negedge clk);
         end
      end
      check("reached_addr2", hit, 1);
      row_valid = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("midrst_busy", busy, 0);
      check("midrst_row_req", row_req, 0);
      check("midrst_out_valid", out_valid, 0);
      check("midrst_out_data", out_data, 0);
      check("midrst_pe_filter", pe_filter, 0);
      fill_random();
      run_image(18'($urandom), 0, 0, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
